// File: rtl/bitslip_align_ctrl.sv
// Word-alignment controller for a SERDES deserializer: pulses BITSLIP until the
// training pattern is seen MATCH_COUNT times in a row, or gives up after MAX_SLIPS.
module bitslip_align_ctrl #(
  parameter int                  DATA_WIDTH    = 8,
  parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = 8'hF0,
  parameter int                  SETTLE_CYCLES = 4,
  parameter int                  MATCH_COUNT   = 16,
  parameter int                  MAX_SLIPS     = 8
) (
  input  logic                  CLK_IN,
  input  logic                  RESET,
  input  logic [DATA_WIDTH-1:0] RX_DATA,
  input  logic                  RX_VALID,
  input  logic                  ALIGN_START,
  output logic                  BITSLIP,
  output logic                  ALIGNED,
  output logic                  ALIGN_FAIL,
  output logic [3:0]            SLIP_COUNT,
  output logic [2:0]            STATE_DBG
);

  localparam int MW = $clog2(MATCH_COUNT + 1);
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [MW-1:0] C_MATCH_LAST  = MW'(MATCH_COUNT - 1);
  localparam logic [MW-1:0] C_MATCH_FULL  = MW'(MATCH_COUNT);
  localparam logic [SW-1:0] C_SETTLE_LAST = SW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [3:0]    C_MAX_SLIPS   = 4'(MAX_SLIPS);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_SLIP   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_LOCKED = 3'd4,
    ST_FAIL   = 3'd5
  } state_t;

  state_t          r_state;
  logic            r_bitslip;
  logic            r_aligned;
  logic            r_fail;
  logic [3:0]      r_slip_cnt;
  logic [MW-1:0]   r_match_cnt;
  logic [SW-1:0]   r_settle_cnt;

  logic            w_match;
  assign w_match = (RX_DATA == TRAIN_PATTERN);

  // Status outputs are set on the same edge that enters their state, so each
  // one is a flop that tracks the state exactly.
  always_ff @(posedge CLK_IN or posedge RESET) begin
    if (RESET) begin
      r_state      <= ST_IDLE;
      r_bitslip    <= 1'b0;
      r_aligned    <= 1'b0;
      r_fail       <= 1'b0;
      r_slip_cnt   <= '0;
      r_match_cnt  <= '0;
      r_settle_cnt <= '0;
    end else begin
      r_bitslip <= 1'b0;
      if (ALIGN_START) begin
        r_state      <= ST_CHECK;
        r_aligned    <= 1'b0;
        r_fail       <= 1'b0;
        r_slip_cnt   <= '0;
        r_match_cnt  <= '0;
        r_settle_cnt <= '0;
      end else begin
        case (r_state)
          ST_CHECK: begin
            if (RX_VALID) begin
              if (w_match) begin
                if (r_match_cnt >= C_MATCH_LAST) begin
                  r_state     <= ST_LOCKED;
                  r_aligned   <= 1'b1;
                  r_match_cnt <= C_MATCH_FULL;
                end else begin
                  r_match_cnt <= r_match_cnt + 1'b1;
                end
              end else begin
                r_match_cnt <= '0;
                if (r_slip_cnt < C_MAX_SLIPS) begin
                  r_state    <= ST_SLIP;
                  r_bitslip  <= 1'b1;
                  r_slip_cnt <= r_slip_cnt + 1'b1;
                end else begin
                  r_state <= ST_FAIL;
                  r_fail  <= 1'b1;
                end
              end
            end
          end
          ST_SLIP: begin
            r_settle_cnt <= '0;
            r_state      <= (SETTLE_CYCLES > 0) ? ST_WAIT : ST_CHECK;
          end
          ST_WAIT: begin
            if (r_settle_cnt >= C_SETTLE_LAST) begin
              r_settle_cnt <= '0;
              r_state      <= ST_CHECK;
            end else begin
              r_settle_cnt <= r_settle_cnt + 1'b1;
            end
          end
          default: begin
            // IDLE, LOCKED and FAIL hold until ALIGN_START
            r_state <= r_state;
          end
        endcase
      end
    end
  end

  assign BITSLIP    = r_bitslip;
  assign ALIGNED    = r_aligned;
  assign ALIGN_FAIL = r_fail;
  assign SLIP_COUNT = r_slip_cnt;
  assign STATE_DBG  = r_state;

endmodule

// File: tb/tb_bitslip_align_ctrl.sv
// Directed bench for bitslip_align_ctrl: a vector table for the slip/settle
// timing plus hand-written lock, rotation, failure and reset sequences.
module tb_bitslip_align_ctrl;

  localparam logic [7:0] TRAIN = 8'hF0;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       align_start;
  logic       bitslip;
  logic       aligned;
  logic       align_fail;
  logic [3:0] slip_count;
  logic [2:0] state_dbg;

  int checks = 0;
  int errors = 0;

  bitslip_align_ctrl dut (
    .CLK_IN      (clk),
    .RESET       (rst),
    .RX_DATA     (rx_data),
    .RX_VALID    (rx_valid),
    .ALIGN_START (align_start),
    .BITSLIP     (bitslip),
    .ALIGNED     (aligned),
    .ALIGN_FAIL  (align_fail),
    .SLIP_COUNT  (slip_count),
    .STATE_DBG   (state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic       valid;
    logic [7:0] data;
    logic [2:0] st;
    logic       bs;
    logic       al;
    logic       fl;
    logic [3:0] sc;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string name, input int st, input int bs, input int al,
                          input int fl, input int sc);
    chk({name, ".state"},   int'(state_dbg),  st);
    chk({name, ".bitslip"}, int'(bitslip),    bs);
    chk({name, ".aligned"}, int'(aligned),    al);
    chk({name, ".fail"},    int'(align_fail), fl);
    chk({name, ".slips"},   int'(slip_count), sc);
  endtask

  // Apply one cycle of inputs, then sample 1 ns after the rising edge.
  task automatic cycle(input logic st, input logic v, input logic [7:0] d);
    align_start = st;
    rx_valid    = v;
    rx_data     = d;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
    logic [15:0] t;
    t = {v, v} << k;
    return t[15:8];
  endfunction

  initial begin
    int   pulses;
    int   last;
    int   rot;
    logic prev;

    // slip/settle timing: mismatch, SLIP, 4 WAIT cycles, CHECK, start beats mismatch
    tbl[0]  = '{1'b1, 1'b0, 8'h00, 3'd1, 1'b0, 1'b0, 1'b0, 4'd0};
    tbl[1]  = '{1'b0, 1'b1, 8'h00, 3'd2, 1'b1, 1'b0, 1'b0, 4'd1};
    tbl[2]  = '{1'b0, 1'b1, 8'hF0, 3'd3, 1'b0, 1'b0, 1'b0, 4'd1};
    tbl[3]  = '{1'b0, 1'b1, 8'h00, 3'd3, 1'b0, 1'b0, 1'b0, 4'd1};
    tbl[4]  = '{1'b0, 1'b1, 8'h00, 3'd3, 1'b0, 1'b0, 1'b0, 4'd1};
    tbl[5]  = '{1'b0, 1'b1, 8'h00, 3'd3, 1'b0, 1'b0, 1'b0, 4'd1};
    tbl[6]  = '{1'b0, 1'b1, 8'h00, 3'd1, 1'b0, 1'b0, 1'b0, 4'd1};
    tbl[7]  = '{1'b0, 1'b0, 8'h00, 3'd1, 1'b0, 1'b0, 1'b0, 4'd1};
    tbl[8]  = '{1'b0, 1'b1, 8'hF0, 3'd1, 1'b0, 1'b0, 1'b0, 4'd1};
    tbl[9]  = '{1'b1, 1'b1, 8'h00, 3'd1, 1'b0, 1'b0, 1'b0, 4'd0};
    tbl[10] = '{1'b0, 1'b1, 8'hF0, 3'd1, 1'b0, 1'b0, 1'b0, 4'd0};

    rst = 1'b1; align_start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk_outs("reset", 0, 0, 0, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'h00);
    chk_outs("idle_hold", 0, 0, 0, 0, 0);

    for (int i = 0; i < 11; i++) begin
      cycle(tbl[i].start, tbl[i].valid, tbl[i].data);
      chk_outs($sformatf("vec%0d", i), int'(tbl[i].st), int'(tbl[i].bs), int'(tbl[i].al),
               int'(tbl[i].fl), int'(tbl[i].sc));
      $display("vec %0d: start=%0b valid=%0b data=%h -> state=%0d bs=%0b slips=%0d",
               i, tbl[i].start, tbl[i].valid, tbl[i].data, state_dbg, bitslip, slip_count);
    end

    // 16 aligned words lock on the 16th
    cycle(1'b1, 1'b0, 8'h00);
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b0, 1'b1, TRAIN);
      chk($sformatf("lock_noslip%0d", i), int'(bitslip), 0);
      if (i == 15) chk_outs("lock_w15", 1, 0, 0, 0, 0);
    end
    chk_outs("lock_w16", 4, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'h00);
    chk_outs("lock_hold", 4, 0, 1, 0, 0);
    $display("seq lock: aligned=%0b slips=%0d", aligned, slip_count);

    // start while locked, with a mismatching word
    cycle(1'b1, 1'b1, 8'h00);
    chk_outs("restart_locked", 1, 0, 0, 0, 0);
    $display("seq restart: state=%0d aligned=%0b", state_dbg, aligned);

    // invalid cycles do not break consecutiveness
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, TRAIN);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, TRAIN);
    chk_outs("gap_w15", 1, 0, 0, 0, 0);
    cycle(1'b0, 1'b1, TRAIN);
    chk_outs("gap_w16", 4, 0, 1, 0, 0);
    $display("seq gap: aligned=%0b slips=%0d", aligned, slip_count);

    // deserializer rotated by 3; each slip rotates back one bit
    rot = 3; pulses = 0; last = -100; prev = 1'b0;
    cycle(1'b1, 1'b0, 8'h00);
    for (int c = 0; c < 300 && !aligned; c++) begin
      cycle(1'b0, 1'b1, rotl8(TRAIN, rot));
      if (bitslip) begin
        pulses++;
        chk("rot_width", int'(prev), 0);
        chk("rot_gap_ge5", int'(c - last >= 5), 1);
        last = c;
        rot  = (rot + 7) % 8;
      end
      prev = bitslip;
    end
    chk("rot_pulses", pulses, 3);
    chk_outs("rot_end", 4, 0, 1, 0, 3);
    $display("seq rotate: pulses=%0d aligned=%0b slips=%0d", pulses, aligned, slip_count);

    // no pattern ever: 8 slips then failure, no ninth pulse
    pulses = 0;
    cycle(1'b1, 1'b0, 8'h00);
    for (int c = 0; c < 300 && !align_fail; c++) begin
      cycle(1'b0, 1'b1, 8'h00);
      if (bitslip) pulses++;
    end
    chk("fail_pulses", pulses, 8);
    chk_outs("fail_end", 5, 0, 0, 1, 8);
    for (int c = 0; c < 20; c++) begin
      cycle(1'b0, 1'b1, 8'h00);
      if (bitslip) pulses++;
    end
    chk("fail_no_ninth", pulses, 8);
    chk_outs("fail_hold", 5, 0, 0, 1, 8);
    $display("seq fail: pulses=%0d fail=%0b slips=%0d", pulses, align_fail, slip_count);

    // reset during SLIP kills the pulse at once
    cycle(1'b1, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 8'h00);
    chk("rst_pre_slip", int'(bitslip), 1);
    rst = 1'b1;
    #1;
    chk_outs("rst_in_slip", 0, 0, 0, 0, 0);
    #2;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 8'h00);
    chk_outs("rst_idle", 0, 0, 0, 0, 0);
    cycle(1'b1, 1'b0, 8'h00);
    chk_outs("rst_restart", 1, 0, 0, 0, 0);
    $display("seq reset: state=%0d bs=%0b", state_dbg, bitslip);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bitslip_align_ctrl.md
BITSLIP_ALIGN_CTRL -- requirements
Module: bitslip_align_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of the deserialized parallel word.
REQ-002 Parameter TRAIN_PATTERN, default 8'hF0: training word expected when correctly aligned.
REQ-003 Parameter SETTLE_CYCLES, default 4: wait cycles after each BITSLIP pulse before data is checked again.
REQ-004 Parameter MATCH_COUNT, default 16: number of consecutive matching valid words required for lock.
REQ-005 Parameter MAX_SLIPS, default 8: number of slips allowed before failure; the legal range is 1..15.
REQ-006 Port CLK_IN, input, 1 bit: divided fabric clock; the block has one clock, and all logic is on its rising edge.
REQ-007 Port RESET, input, 1 bit: asynchronous, active-high reset.
REQ-008 Port RX_DATA, input, DATA_WIDTH bits: parallel word from the deserializer.
REQ-009 Port RX_VALID, input, 1 bit: RX_DATA is valid this cycle.
REQ-010 Port ALIGN_START, input, 1 bit: single-cycle request to start or restart alignment.
REQ-011 Port BITSLIP, output, 1 bit: single-cycle slip pulse to the deserializer.
REQ-012 Port ALIGNED, output, 1 bit: lock achieved.
REQ-013 Port ALIGN_FAIL, output, 1 bit: all slip positions exhausted without lock.
REQ-014 Port SLIP_COUNT, output, 4 bits: number of slips issued in the current attempt.
REQ-015 Port STATE_DBG, output, 3 bits: current FSM state encoding.

Function
REQ-016 The FSM SHALL have states IDLE=0, CHECK=1, SLIP=2, WAIT=3, LOCKED=4, FAIL=5.
REQ-017 All outputs SHALL be registered.
- BITSLIP is high exactly while the FSM is in SLIP.
- ALIGNED is high exactly while the FSM is in LOCKED.
- ALIGN_FAIL is high exactly while the FSM is in FAIL.
REQ-018 ALIGN_START in any state SHALL move the FSM to CHECK on the next cycle and clear SLIP_COUNT, the match counter and the settle counter.
REQ-019 ALIGN_START SHALL take priority over every other event in the same cycle, including a mismatch, a final match or settle expiry.
REQ-020 In CHECK, a cycle with RX_VALID=1 and RX_DATA==TRAIN_PATTERN SHALL increment the match counter.
REQ-021 When the match counter reaches MATCH_COUNT, the FSM SHALL enter LOCKED on the next cycle.
- ALIGNED=1 starts in the cycle after the MATCH_COUNT-th matching word.
REQ-022 In CHECK, cycles with RX_VALID=0 SHALL be ignored; they do not break consecutiveness.
REQ-023 In CHECK, a cycle with RX_VALID=1 and a mismatching word while SLIP_COUNT<MAX_SLIPS SHALL move the FSM to SLIP on the next cycle.
- The match counter clears.
- SLIP_COUNT increments on entry to SLIP.
REQ-024 In CHECK, a mismatching valid word while SLIP_COUNT==MAX_SLIPS SHALL move the FSM to FAIL without a BITSLIP pulse.
REQ-025 SLIP SHALL last exactly one cycle and then go to WAIT.
REQ-026 WAIT SHALL last exactly SETTLE_CYCLES cycles and ignore RX_DATA and RX_VALID, then go to CHECK.
- Timing: a mismatch in cycle N gives BITSLIP in N+1, WAIT in N+2..N+1+SETTLE_CYCLES, and CHECK from N+2+SETTLE_CYCLES.
REQ-027 LOCKED and FAIL SHALL hold, ignoring RX data, until ALIGN_START or RESET.
- SLIP_COUNT holds its final value in these states.
REQ-028 IDLE SHALL be left only on ALIGN_START.
REQ-029 The match counter SHALL be wide enough for MATCH_COUNT and SHALL never wrap.
REQ-030 SLIP_COUNT SHALL never exceed MAX_SLIPS.

Reset
REQ-031 While RESET=1, asynchronously, the block SHALL force all of the following:
- FSM to IDLE.
- BITSLIP=0, ALIGNED=0, ALIGN_FAIL=0.
- SLIP_COUNT=0, STATE_DBG=0.
- All internal counters to 0.
REQ-032 RESET asserted mid-alignment, including during SLIP, SHALL end any BITSLIP pulse immediately.
REQ-033 After RESET releases, the block SHALL stay in IDLE until ALIGN_START.

Verification
REQ-034 Scenario: ALIGN_START, then RX_DATA=8'hF0 with RX_VALID=1 for 16 cycles.
- Required: no BITSLIP; ALIGNED=1 in the cycle after the 16th word; SLIP_COUNT=0.
REQ-035 Scenario: deserializer model rotated by 3 bits; each BITSLIP rotates it by one bit.
- Required: exactly 3 BITSLIP pulses, each 1 cycle wide and at least 5 cycles apart.
- Then ALIGNED=1 with SLIP_COUNT=3.
REQ-036 Scenario: RX_DATA constant 8'h00 after ALIGN_START.
- Required: 8 BITSLIP pulses, then ALIGN_FAIL=1 with SLIP_COUNT=8; no ninth pulse.
REQ-037 Scenario: 10 matching words, 3 idle cycles with RX_VALID=0, then 6 matching words.
- Required: lock after the 16th matching word with no slip.
REQ-038 Scenario: ALIGN_START in the same cycle as a mismatch during CHECK, and again while in LOCKED.
- Required: no BITSLIP; CHECK next cycle; SLIP_COUNT=0; ALIGNED falls the next cycle.
REQ-039 Scenario: RESET asserted during SLIP, then released.
- Required: BITSLIP=0 immediately and all outputs 0.
- STATE_DBG=0 until ALIGN_START.
